// File: rtl/hazard_branch_ctrl.sv
// ID-stage hazard / branch controller: two-slot destination scoreboard, load-use and
// branch-operand stalls, ID-resolved redirects. Optional counters under HAZARD_PERF_CNT_EN.
module hazard_branch_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instruction_F,
   input  logic [31:0] NPC_F,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        ext_stall,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   output logic        disable_PC,
   output logic        disable_IR,
   output logic        KILL,
   output logic [1:0]  PCsrc,
   output logic [31:0] PC_offset,
   output logic [31:0] PC_regRs
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_ADDI  = 6'd1;
   localparam logic [5:0] OP_LW    = 6'd2;
   localparam logic [5:0] OP_SW    = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_J     = 6'd6;
   localparam logic [5:0] OP_JR    = 6'd7;

   logic        id_valid_reg;
   logic        ex_valid_reg, ex_load_reg, mem_valid_reg, mem_load_reg;
   logic [4:0]  ex_rd_reg, mem_rd_reg;

   logic [31:0] id_instr;
   logic [5:0]  opcode;
   logic [4:0]  fld_rd, fld_rs, fld_rt, read_b;
   logic        reads_a, reads_b, writes, is_load, is_branch;
   logic        hazard, taken;
   logic [1:0]  taken_src;

   // Until the first unfrozen edge the IF/ID contents are undefined, so decode a NOP.
   assign id_instr = id_valid_reg ? Instruction_F : 32'd0;
   assign opcode   = id_instr[31:26];
   assign fld_rd   = id_instr[25:21];
   assign fld_rs   = id_instr[20:16];
   assign fld_rt   = id_instr[15:11];

   assign rs_addr  = Instruction_F[20:16];
   assign PC_regRs = rs_val;

   always_comb begin
      case (Instruction_F[31:26])
         OP_RTYPE:               rt_addr = Instruction_F[15:11];
         OP_SW, OP_BEQ, OP_BNE:  rt_addr = Instruction_F[25:21];
         default:                rt_addr = 5'd0;
      endcase
   end

   always_comb begin
      reads_a   = 1'b0;
      reads_b   = 1'b0;
      read_b    = 5'd0;
      writes    = 1'b0;
      is_load   = 1'b0;
      is_branch = 1'b0;
      case (opcode)
         OP_RTYPE: begin reads_a = 1'b1; reads_b = 1'b1; read_b = fld_rt; writes = 1'b1; end
         OP_ADDI:  begin reads_a = 1'b1; writes = 1'b1; end
         OP_LW:    begin reads_a = 1'b1; writes = 1'b1; is_load = 1'b1; end
         OP_SW:    begin reads_a = 1'b1; reads_b = 1'b1; read_b = fld_rd; end
         OP_BEQ, OP_BNE: begin
            reads_a = 1'b1; reads_b = 1'b1; read_b = fld_rd; is_branch = 1'b1;
         end
         OP_JR:    begin reads_a = 1'b1; is_branch = 1'b1; end
         default:  ;
      endcase
   end

   function automatic logic slot_match(input logic v, input logic [4:0] rd, input logic [4:0] r);
      return v && (rd == r) && (r != 5'd0);
   endfunction

   logic a_ex, b_ex, a_mem, b_mem;
   assign a_ex  = reads_a && slot_match(ex_valid_reg, ex_rd_reg, fld_rs);
   assign b_ex  = reads_b && slot_match(ex_valid_reg, ex_rd_reg, read_b);
   assign a_mem = reads_a && slot_match(mem_valid_reg, mem_rd_reg, fld_rs);
   assign b_mem = reads_b && slot_match(mem_valid_reg, mem_rd_reg, read_b);

   // Branches compare in ID, so they need the operand one stage earlier than ALU users.
   assign hazard = is_branch ? ((a_ex || b_ex) || ((a_mem || b_mem) && mem_load_reg))
                             : ((a_ex || b_ex) && ex_load_reg);

   always_comb begin
      taken     = 1'b0;
      taken_src = 2'b01;
      case (opcode)
         OP_J:    taken = 1'b1;
         OP_BEQ:  taken = (rs_val == rt_val);
         OP_BNE:  taken = (rs_val != rt_val);
         OP_JR:   begin taken = 1'b1; taken_src = 2'b10; end
         default: ;
      endcase
   end

   assign PC_offset = (opcode == OP_J) ? NPC_F + {{6{id_instr[25]}}, id_instr[25:0]}
                                       : NPC_F + {{16{id_instr[15]}}, id_instr[15:0]};

   always_comb begin
      disable_PC = 1'b0;
      disable_IR = 1'b0;
      KILL       = 1'b0;
      PCsrc      = 2'b00;
      if (reset) begin
         disable_PC = 1'b0;
      end else if (ext_stall || hazard) begin
         disable_PC = 1'b1;
         disable_IR = 1'b1;
      end else if (taken) begin
         KILL  = 1'b1;
         PCsrc = taken_src;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_valid_reg  <= 1'b0;
         ex_valid_reg  <= 1'b0;
         ex_load_reg   <= 1'b0;
         ex_rd_reg     <= 5'd0;
         mem_valid_reg <= 1'b0;
         mem_load_reg  <= 1'b0;
         mem_rd_reg    <= 5'd0;
      end else if (!ext_stall) begin
         id_valid_reg  <= 1'b1;
         mem_valid_reg <= ex_valid_reg;
         mem_load_reg  <= ex_load_reg;
         mem_rd_reg    <= ex_rd_reg;
         if (hazard) begin
            ex_valid_reg <= 1'b0;
            ex_load_reg  <= 1'b0;
            ex_rd_reg    <= 5'd0;
         end else begin
            ex_valid_reg <= writes && (fld_rd != 5'd0);
            ex_load_reg  <= is_load;
            ex_rd_reg    <= fld_rd;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (!ext_stall && hazard) stall_cnt <= stall_cnt + 32'd1;
         if (KILL)                 flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_branch_ctrl.sv
// Directed-vector bench for hazard_branch_ctrl: stimulus queues expected per-cycle
// control outputs, a separate monitor pops and compares on the falling edge.
module tb_hazard_branch_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] Instruction_F = 32'd0, NPC_F = 32'd0, rs_val = 32'd0, rt_val = 32'd0;
   logic        ext_stall = 1'b0;
   logic [4:0]  rs_addr, rt_addr;
   logic        disable_PC, disable_IR, KILL;
   logic [1:0]  PCsrc;
   logic [31:0] PC_offset, PC_regRs;

   hazard_branch_ctrl dut (
      .clk(clk), .reset(reset), .Instruction_F(Instruction_F), .NPC_F(NPC_F),
      .rs_val(rs_val), .rt_val(rt_val), .ext_stall(ext_stall),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .disable_PC(disable_PC), .disable_IR(disable_IR),
      .KILL(KILL), .PCsrc(PCsrc), .PC_offset(PC_offset), .PC_regRs(PC_regRs)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(), .flush_cnt()
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic        stall;
      logic        kill;
      logic [1:0]  src;
      logic        chk_off;
      logic [31:0] off;
      logic        chk_rs;
      logic [31:0] regrs;
      int          rt;
   } exp_t;

   typedef struct {
      logic        rst;
      logic        xs;
      logic [31:0] instr, npc, rsv, rtv;
      exp_t        e;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   bit   stim_done = 1'b0;

   function automatic logic [31:0] enc(input int op, input int rd, input int rs,
                                       input int rt, input int imm16);
      logic [5:0] o; logic [4:0] d, s, t; logic [15:0] i; logic [31:0] w;
      o = op[5:0]; d = rd[4:0]; s = rs[4:0]; t = rt[4:0]; i = imm16[15:0];
      w = {o, d, s, i};
      w[15:11] = (op == 0) ? t : i[15:11];
      return w;
   endfunction

   task automatic add(input logic rst, input logic xs, input logic [31:0] instr,
                      input logic [31:0] npc, input logic [31:0] rsv, input logic [31:0] rtv,
                      input logic stall, input logic kill, input logic [1:0] src,
                      input logic chk_off, input logic [31:0] off,
                      input logic chk_rs, input int rt);
      vec_t v;
      v.rst = rst; v.xs = xs; v.instr = instr; v.npc = npc; v.rsv = rsv; v.rtv = rtv;
      v.e.id = vecs.size(); v.e.stall = stall; v.e.kill = kill; v.e.src = src;
      v.e.chk_off = chk_off; v.e.off = off; v.e.chk_rs = chk_rs; v.e.regrs = rsv; v.e.rt = rt;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int id, input logic [31:0] act,
                        input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, id, act, req);
      end
   endtask

   // Monitor: the controller presents a control word every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("disable_PC", e.id, {31'd0, disable_PC}, {31'd0, e.stall});
            check("disable_IR", e.id, {31'd0, disable_IR}, {31'd0, e.stall});
            check("KILL",       e.id, {31'd0, KILL},       {31'd0, e.kill});
            check("PCsrc",      e.id, {30'd0, PCsrc},      {30'd0, e.src});
            if (e.chk_off) check("PC_offset", e.id, PC_offset, e.off);
            if (e.chk_rs)  check("PC_regRs",  e.id, PC_regRs,  e.regrs);
            if (e.rt >= 0) check("rt_addr",   e.id, {27'd0, rt_addr}, e.rt);
            $display("cyc %0d rst=%0b xs=%0b dPC=%0b dIR=%0b KILL=%0b PCsrc=%0d off=%08h",
                     e.id, reset, ext_stall, disable_PC, disable_IR, KILL, PCsrc, PC_offset);
         end
      end
   end

   initial begin
      logic [31:0] j_m1, junk_j;
      j_m1   = {6'd6, 26'h3FFFFFF};
      junk_j = {6'd6, 26'h0000100};
      //  rst xs  instr                       npc     rsv    rtv  stall kill src chk_off off  chk_rs rt
      add(1, 1, junk_j,                       32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, junk_j,                       32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, 32'd0,                        32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, 0);
      add(0, 0, enc(2, 5, 1, 0, 0),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, 0);
      add(0, 0, enc(1, 6, 5, 0, 1),           32'h0,  0,     0,   1, 0, 2'b00, 0, 0, 0, 0);
      add(0, 0, enc(1, 6, 5, 0, 1),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, 0);
      add(0, 0, enc(1, 3, 0, 0, 9),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, enc(4, 4, 3, 0, 4),           32'h10, 7,     7,   1, 0, 2'b00, 0, 0, 0, 4);
      add(0, 0, enc(4, 4, 3, 0, 4),           32'h10, 7,     7,   0, 1, 2'b01, 1, 32'h14, 0, 4);
      add(0, 0, enc(2, 2, 0, 0, 0),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, enc(7, 0, 2, 0, 0),           32'h0,  32'h40, 0,  1, 0, 2'b00, 0, 0, 1, 0);
      add(0, 0, enc(7, 0, 2, 0, 0),           32'h0,  32'h40, 0,  1, 0, 2'b00, 0, 0, 1, 0);
      add(0, 0, enc(7, 0, 2, 0, 0),           32'h0,  32'h40, 0,  0, 1, 2'b10, 0, 0, 1, 0);
      add(0, 0, enc(5, 1, 1, 0, -2),          32'h0,  5,     5,   0, 0, 2'b00, 1, 32'hFFFFFFFE, 0, 1);
      add(0, 0, j_m1,                         32'h0,  0,     0,   0, 1, 2'b01, 1, 32'hFFFFFFFF, 0, 0);
      add(0, 0, enc(2, 7, 0, 0, 0),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 1, enc(1, 8, 7, 0, 0),           32'h0,  0,     0,   1, 0, 2'b00, 0, 0, 0, -1);
      add(0, 1, enc(1, 8, 7, 0, 0),           32'h0,  0,     0,   1, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, enc(1, 8, 7, 0, 0),           32'h0,  0,     0,   1, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, enc(1, 8, 7, 0, 0),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, enc(2, 0, 0, 0, 0),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, enc(4, 0, 0, 0, 1),           32'h20, 0,     0,   0, 1, 2'b01, 1, 32'h21, 0, 0);
      add(0, 0, enc(2, 5, 1, 0, 0),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, enc(1, 6, 5, 0, 1),           32'h0,  0,     0,   1, 0, 2'b00, 0, 0, 0, -1);
      add(1, 0, enc(1, 6, 5, 0, 1),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, enc(1, 6, 5, 0, 1),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, enc(1, 6, 5, 0, 1),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, -1);
      add(0, 0, {6'd9, 26'h3FFFFFF},          32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, 0);
      add(0, 0, enc(4, 2, 1, 0, 3),           32'h8,  1,     2,   0, 0, 2'b00, 1, 32'hB, 0, 2);
      add(0, 0, enc(5, 2, 1, 0, 3),           32'h8,  1,     2,   0, 1, 2'b01, 1, 32'hB, 0, 2);
      add(0, 0, enc(0, 9, 3, 4, 0),           32'h0,  0,     0,   0, 0, 2'b00, 0, 0, 0, 4);

      @(posedge clk);
      foreach (vecs[i]) begin
         #1;
         reset         = vecs[i].rst;
         ext_stall     = vecs[i].xs;
         Instruction_F = vecs[i].instr;
         NPC_F         = vecs[i].npc;
         rs_val        = vecs[i].rsv;
         rt_val        = vecs[i].rtv;
         sb.push_back(vecs[i].e);
         @(posedge clk);
      end
      stim_done = 1'b1;
   end

   initial begin
      int budget;
      budget = 0;
      while (!(stim_done && sb.size() == 0) && budget < 2000) begin
         @(posedge clk);
         budget++;
      end
      total++;
      if (budget >= 2000) begin
         bad++;
         $display("FAIL timeout pending=%0d", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_branch_ctrl.md
Name: hazard_branch_ctrl

Overview:
- ID-side controller that drives the fetch stage's PC/IF-ID control inputs: disable_PC, disable_IR, KILL, PCsrc, PC_offset and PC_regRs.
- Decodes the IF/ID instruction, resolves branches and jumps in ID, and computes redirect targets.
- Tracks in-flight destination registers in a two-slot scoreboard (EX, MEM) and stalls on load-use and branch-operand hazards.

Parameters:
- OP_RTYPE, 6'd0, R-type ALU; reads Rs,Rt; writes Rd
- OP_ADDI, 6'd1, reads Rs; writes Rd
- OP_LW, 6'd2, reads Rs; writes Rd; load
- OP_SW, 6'd3, reads Rs, Rd-field
- OP_BEQ, 6'd4, reads Rs, Rd-field; imm16 offset
- OP_BNE, 6'd5, same as BEQ
- OP_J, 6'd6, no reads; imm26 offset
- OP_JR, 6'd7, reads Rs

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- Instruction_F  in  32  IF/ID instruction
- NPC_F  in  32  IF/ID PC+1
- rs_val  in  32  regfile read of rs_addr, MEM-stage forwarding already applied
- rt_val  in  32  regfile read of rt_addr, MEM-stage forwarding already applied
- ext_stall  in  1  memory-system freeze
- rs_addr  out  5  Instruction_F[20:16]
- rt_addr  out  5  [15:11] for RTYPE; [25:21] for SW/BEQ/BNE; else 0
- disable_PC  out  1  hold PC
- disable_IR  out  1  hold IF/ID
- KILL  out  1  load NOP into IF/ID
- PCsrc  out  2  00 PC+1, 01 PC_offset, 10 PC_regRs
- PC_offset  out  32  branch/jump target
- PC_regRs  out  32  JR target, equals rs_val

Behaviour:
- Fields:
  - opcode [31:26], Rd [25:21], Rs [20:16], Rt [15:11], imm16 [15:0], imm26 [25:0].
  - Unknown opcodes: no reads, no writes, no redirect.
- id_valid register:
  - Cleared by reset.
  - Set at first clk edge with ext_stall=0.
  - While 0, the ID instruction is treated as NOP (all-zero).
- Scoreboard: slots EX and MEM, each holding {valid, is_load, rd}. Reset clears all fields.
  - ext_stall=1: both slots hold.
  - Hazard stall: EX <= bubble (valid=0); MEM <= EX.
  - Otherwise: EX <= ID decode, with valid=1 only for writers with rd!=0; MEM <= EX.
  - Redirect cycle: the ID branch/jump itself shifts in as a non-writer. The killed instruction never enters ID.
- Match rule: register r matches a slot iff slot.valid, slot.rd==r, and r!=0.
- Hazard (combinational):
  - Non-branch readers: stall if a read register matches the EX slot with is_load=1.
  - BEQ/BNE/JR: stall if a read register matches the EX slot (any writer), or matches the MEM slot with is_load=1.
  - Each stall lasts exactly as many cycles as the producer needs to clear the condition (1 cycle for ALU-in-EX; 2 cycles for a load in EX ahead of a branch).
- Targets:
  - PC_offset = NPC_F + sext(imm16) for BEQ/BNE; NPC_F + sext(imm26) for J. 32-bit, wrap-around modulo 2^32.
  - PC_regRs = rs_val.
- Redirect:
  - J: always taken.
  - BEQ: taken iff rs_val==rt_val. BNE: taken iff rs_val!=rt_val.
  - JR: PCsrc=10.
  - Taken: PCsrc=01 (J/BEQ/BNE) or 10 (JR), KILL=1, disable_PC=0, disable_IR=0.
  - Not taken: PCsrc=00, KILL=0.
- Output priority (all outputs combinational from state + inputs):
  1. reset asserted: disable_PC=0, disable_IR=0, KILL=0, PCsrc=00.
  2. ext_stall: disable_PC=1, disable_IR=1, KILL=0, PCsrc=00.
  3. Hazard stall: disable_PC=1, disable_IR=1, KILL=0, PCsrc=00. A branch is never resolved while stalled.
  4. Redirect.
  5. Default: all 0, PCsrc=00.
- Reset mid-stall: scoreboard and id_valid clear immediately; no residual stall after release.
- R0 is never a hazard source.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments per hazard-stall cycle; ext_stall cycles are not counted.
  - flush_cnt increments per KILL cycle.
  - Both clear on reset and wrap at 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then NOP stream -> all control outputs 0, PCsrc=00; id_valid=0 in the first cycle suppresses X decode.
- LW R5 then ADDI R6,R5 -> exactly 1 cycle disable_PC=disable_IR=1; bubble enters EX; ADDI then proceeds.
- ADDI R3 then BEQ R3,R4,+4 with rs_val=rt_val=7, NPC_F=0x10 -> 1 stall cycle, then PCsrc=01, PC_offset=0x14, KILL=1.
- LW R2 then JR R2 with rs_val=0x40 -> 2 stall cycles, then PCsrc=10, PC_regRs=0x40, KILL=1.
- BNE R1,R1,-2 at NPC_F=0 -> not taken, PCsrc=00, KILL=0. J with imm26=-1 at NPC_F=0 -> PC_offset=0xFFFFFFFF.
- ext_stall=1 during a pending load-use -> freeze, no KILL, scoreboard held; load-use stall resumes after release. LW R0 followed by a reader of R0 -> no stall.
